// File: rtl/ascon_decrypt_if.sv
// Host-side bus of the ASCON-128 decryption engine.
// The host (master) drives the key/nonce/tag, the start pulse and the data
// blocks; the engine (slave) returns the plaintext stream and the verdict.
interface ascon_decrypt_if;
  logic         start_i;
  logic         data_valid_i;
  logic [63:0]  data_i;
  logic [127:0] key_i;
  logic [127:0] nonce_i;
  logic [127:0] tag_i;
  logic         plain_valid_o;
  logic [63:0]  plain_o;
  logic         end_o;
  logic         tag_ok_o;
  logic [127:0] tag_o;

  modport master (
    output start_i, data_valid_i, data_i, key_i, nonce_i, tag_i,
    input  plain_valid_o, plain_o, end_o, tag_ok_o, tag_o
  );

  modport slave (
    input  start_i, data_valid_i, data_i, key_i, nonce_i, tag_i,
    output plain_valid_o, plain_o, end_o, tag_ok_o, tag_o
  );
endinterface

// File: rtl/ascon_decrypt_top.sv
// ASCON-128 authenticated decryption: one padded AD block, three 64-bit
// ciphertext blocks, one permutation round per clock.
// Optional feature macro: ASCON_DEC_TAG_OUT_EN -- when defined, the computed
// tag is driven on tag_o while end_o is high; otherwise tag_o is tied to 0.
module ascon_decrypt_top (
  input  logic           clock_i,
  input  logic           resetb_i,
  ascon_decrypt_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, INIT, WAIT_AD, AD, WAIT_CT, CT, FINAL, DONE
  } fsm_t;

  localparam logic [63:0] IV      = 64'h80400C0600000000;
  localparam logic [63:0] PAD_BLK = 64'h8000000000000000;

  fsm_t         state, state_nxt;
  logic [319:0] s, s_nxt;          // x0 = s[319:256] ... x4 = s[63:0]
  logic [319:0] rout;
  logic [3:0]   rnd, rnd_nxt;
  logic [1:0]   blk, blk_nxt;
  logic [127:0] key_q, key_nxt;
  logic [127:0] tag_in_q, tag_in_nxt;
  logic [63:0]  plain_q, plain_nxt;
  logic         pv_q, pv_nxt;
  logic         ok_q, ok_nxt;
  logic [127:0] tag_calc;
  logic [7:0]   rc;
  logic         last;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // One ASCON round: constant addition, bitsliced 5-bit S-box, linear layer.
  function automatic logic [319:0] ascon_round(input logic [319:0] st, input logic [7:0] c);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = st;
    x2 = x2 ^ {56'd0, c};
    x0 = x0 ^ x4;  x4 = x4 ^ x3;  x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1;  x1 = x1 ^ t2;  x2 = x2 ^ t3;  x3 = x3 ^ t4;  x4 = x4 ^ t0;
    x1 = x1 ^ x0;  x0 = x0 ^ x4;  x3 = x3 ^ x2;  x2 = ~x2;
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  // Round constant follows the counter: high nibble 15-r, low nibble r.
  assign rc       = {4'hF - rnd, rnd};
  assign last     = (rnd == 4'd11);
  assign rout     = ascon_round(s, rc);
  assign tag_calc = rout[127:0] ^ key_q;

  // Next-state and datapath update for every FSM state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_nxt  = state;
    s_nxt      = s;
    rnd_nxt    = rnd;
    blk_nxt    = blk;
    key_nxt    = key_q;
    tag_in_nxt = tag_in_q;
    plain_nxt  = '0;
    pv_nxt     = 1'b0;
    ok_nxt     = ok_q;

    case (state)
      IDLE, DONE: begin
        if (bus.start_i) begin
          state_nxt  = INIT;
          s_nxt      = {IV, bus.key_i, bus.nonce_i};
          rnd_nxt    = 4'd0;
          blk_nxt    = 2'd0;
          key_nxt    = bus.key_i;
          tag_in_nxt = bus.tag_i;
          ok_nxt     = 1'b0;
        end
      end
      INIT: begin
        s_nxt   = rout;
        rnd_nxt = rnd + 4'd1;
        if (last) begin
          s_nxt[127:0] = rout[127:0] ^ key_q;
          state_nxt    = WAIT_AD;
        end
      end
      WAIT_AD: begin
        if (bus.data_valid_i) begin
          s_nxt[319:256] = s[319:256] ^ bus.data_i;
          rnd_nxt        = 4'd6;
          state_nxt      = AD;
        end
      end
      AD: begin
        s_nxt   = rout;
        rnd_nxt = rnd + 4'd1;
        if (last) begin
          s_nxt[0]  = ~rout[0];
          state_nxt = WAIT_CT;
        end
      end
      WAIT_CT: begin
        if (bus.data_valid_i) begin
          plain_nxt      = s[319:256] ^ bus.data_i;
          pv_nxt         = 1'b1;
          s_nxt[319:256] = bus.data_i;
          blk_nxt        = blk + 2'd1;
          rnd_nxt        = 4'd6;
          state_nxt      = CT;
        end
      end
      CT: begin
        s_nxt   = rout;
        rnd_nxt = rnd + 4'd1;
        if (last) begin
          if (blk == 2'd3) begin
            // Empty padded final block, then key into x1,x2 ahead of finalization.
            s_nxt[319:256] = rout[319:256] ^ PAD_BLK;
            s_nxt[255:128] = rout[255:128] ^ key_q;
            rnd_nxt        = 4'd0;
            state_nxt      = FINAL;
          end else begin
            state_nxt = WAIT_CT;
          end
        end
      end
      FINAL: begin
        s_nxt   = rout;
        rnd_nxt = rnd + 4'd1;
        if (last) begin
          ok_nxt    = (tag_calc == tag_in_q);
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!resetb_i) state <= IDLE;
    else           state <= state_nxt;
  end

  // Permutation state, counters, sampled inputs and registered outputs.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      s        <= '0;
      rnd      <= '0;
      blk      <= '0;
      key_q    <= '0;
      tag_in_q <= '0;
      plain_q  <= '0;
      pv_q     <= 1'b0;
      ok_q     <= 1'b0;
    end else begin
      s        <= s_nxt;
      rnd      <= rnd_nxt;
      blk      <= blk_nxt;
      key_q    <= key_nxt;
      tag_in_q <= tag_in_nxt;
      plain_q  <= plain_nxt;
      pv_q     <= pv_nxt;
      ok_q     <= ok_nxt;
    end
  end

`ifdef ASCON_DEC_TAG_OUT_EN
  logic [127:0] tag_q;

  // Computed tag captured on the last finalization round, held through DONE.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i)                     tag_q <= '0;
    else if (state == FINAL && last)   tag_q <= tag_calc;
  end

  assign bus.tag_o = (state == DONE) ? tag_q : '0;
`else
  assign bus.tag_o = '0;
`endif

  assign bus.plain_valid_o = pv_q;
  assign bus.plain_o       = plain_q;
  assign bus.end_o         = (state == DONE);
  assign bus.tag_ok_o      = (state == DONE) && ok_q;

endmodule

// File: tb/tb_ascon_decrypt_top.sv
// Directed bench for ascon_decrypt_top: round trip against an encrypting
// reference model, bad tag, stray pulses, host gaps, restart from DONE and
// reset mid-message.
module tb_ascon_decrypt_top;

  localparam logic [127:0] KEY   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] NONCE = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [63:0]  AD_BLK = 64'h3230323280000000;
  localparam logic [63:0]  IV    = 64'h80400C0600000000;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  localparam logic [7:0] RC [12] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_mis;

  logic [63:0]  pt [3];
  logic [63:0]  ct [3];
  logic [127:0] exp_tag;
  logic [127:0] exp_tag_o;

  ascon_decrypt_if bus ();

  ascon_decrypt_top dut (
    .clock_i  (clk),
    .resetb_i (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference permutation: table S-box applied column by column.
  function automatic logic [319:0] m_perm(input logic [319:0] st, input int first);
    logic [63:0] a [5];
    logic [63:0] b [5];
    logic [4:0]  col, o;
    for (int k = 0; k < 5; k++) a[k] = st[319 - 64*k -: 64];
    for (int r = first; r < 12; r++) begin
      a[2][7:0] = a[2][7:0] ^ RC[r];
      for (int i = 0; i < 64; i++) begin
        col = {a[0][i], a[1][i], a[2][i], a[3][i], a[4][i]};
        o   = SBOX[col];
        for (int k = 0; k < 5; k++) b[k][i] = o[4-k];
      end
      a[0] = b[0] ^ m_ror(b[0], 19) ^ m_ror(b[0], 28);
      a[1] = b[1] ^ m_ror(b[1], 61) ^ m_ror(b[1], 39);
      a[2] = b[2] ^ m_ror(b[2], 1)  ^ m_ror(b[2], 6);
      a[3] = b[3] ^ m_ror(b[3], 10) ^ m_ror(b[3], 17);
      a[4] = b[4] ^ m_ror(b[4], 7)  ^ m_ror(b[4], 41);
    end
    return {a[0], a[1], a[2], a[3], a[4]};
  endfunction

  // Reference ASCON-128 encryption of pt[] producing ct[] and exp_tag.
  task automatic model_encrypt();
    logic [319:0] st;
    st = m_perm({IV, KEY, NONCE}, 0);
    st[127:0] = st[127:0] ^ KEY;
    st[319:256] = st[319:256] ^ AD_BLK;
    st = m_perm(st, 6);
    st[0] = st[0] ^ 1'b1;
    for (int b = 0; b < 3; b++) begin
      ct[b] = st[319:256] ^ pt[b];
      st[319:256] = ct[b];
      st = m_perm(st, 6);
    end
    st[319:256] = st[319:256] ^ 64'h8000000000000000;
    st[255:128] = st[255:128] ^ KEY;
    st = m_perm(st, 0);
    exp_tag = st[127:0] ^ KEY;
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_pv"},    128'(bus.plain_valid_o), 128'd0);
    check({nm, "_plain"}, 128'(bus.plain_o),       128'd0);
    check({nm, "_end"},   128'(bus.end_o),         128'd0);
    check({nm, "_ok"},    128'(bus.tag_ok_o),      128'd0);
    check({nm, "_tag"},   bus.tag_o,               128'd0);
  endtask

  // One message, host timed from the start edge. abort_blk >= 0 resets the
  // engine while that ciphertext block's plaintext is on the outputs.
  task automatic run_msg(input string nm, input logic [127:0] tg, input int gap,
                         input bit stray, input bit exp_ok, input int exp_lat,
                         input int abort_blk);
    int s_cyc;
    bit seen;
    int lat;
    bus.key_i   = KEY;
    bus.nonce_i = NONCE;
    bus.tag_i   = tg;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    s_cyc = cyc;
    check({nm, "_end_drop"}, 128'(bus.end_o), 128'd0);
    check({nm, "_tag_low"},  bus.tag_o,       128'd0);

    for (int c = 1; c < 13 + gap; c++) begin
      if (stray && c == 5) begin
        bus.data_valid_i = 1'b1;
        bus.data_i       = 64'hDEADBEEFCAFEF00D;
      end
      @(negedge clk);
      bus.data_valid_i = 1'b0;
      bus.data_i       = '0;
    end

    bus.data_valid_i = 1'b1;
    bus.data_i       = AD_BLK;
    @(negedge clk);
    bus.data_valid_i = 1'b0;
    bus.data_i       = '0;
    for (int c = 0; c < 6 + gap; c++) @(negedge clk);

    for (int b = 0; b < 3; b++) begin
      bus.data_valid_i = 1'b1;
      bus.data_i       = ct[b];
      @(negedge clk);
      bus.data_valid_i = 1'b0;
      bus.data_i       = '0;
      check($sformatf("%s_pv%0d", nm, b),    128'(bus.plain_valid_o), 128'd1);
      check($sformatf("%s_plain%0d", nm, b), 128'(bus.plain_o),       128'(pt[b]));
      if (b == abort_blk) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs({nm, "_abort"});
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      check($sformatf("%s_pv%0d_off", nm, b), 128'(bus.plain_valid_o), 128'd0);
      check($sformatf("%s_pl%0d_off", nm, b), 128'(bus.plain_o),       128'd0);
      for (int c = 0; c < 5 + ((b < 2) ? gap : 0); c++) begin
        if (stray && c == 1) begin
          bus.data_valid_i = 1'b1;
          bus.data_i       = 64'h0123456789ABCDEF;
        end
        @(negedge clk);
        bus.data_valid_i = 1'b0;
        bus.data_i       = '0;
      end
    end

    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (bus.end_o) begin
        seen = 1'b1;
      end else begin
        if (stray && c == 3) begin
          bus.start_i = 1'b1;
          bus.key_i   = ~KEY;
          bus.tag_i   = ~tg;
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.key_i   = KEY;
        bus.tag_i   = tg;
      end
    end
    check({nm, "_end_seen"}, 128'(seen), 128'd1);
    lat = cyc - s_cyc + 1;
    check({nm, "_latency"}, 128'(lat), 128'(exp_lat));
    check({nm, "_tag_ok"},  128'(bus.tag_ok_o), 128'(exp_ok));
    check({nm, "_tag_o"},   bus.tag_o, exp_tag_o);
    @(negedge clk);
    check({nm, "_end_hold"}, 128'(bus.end_o), 128'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    cyc   = 0;
    rst_n = 1'b0;
    bus.start_i      = 1'b0;
    bus.data_valid_i = 1'b0;
    bus.data_i       = '0;
    bus.key_i        = '0;
    bus.nonce_i      = '0;
    bus.tag_i        = '0;

    pt[0] = 64'h0001020304050607;
    pt[1] = 64'h08090A0B0C0D0E0F;
    pt[2] = 64'h1011121314151617;
    model_encrypt();
`ifdef ASCON_DEC_TAG_OUT_EN
    exp_tag_o = exp_tag;
`else
    exp_tag_o = '0;
`endif

    repeat (3) @(negedge clk);
    check_idle_outputs("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");

    run_msg("rst_blk2", exp_tag,                 0, 1'b0, 1'b1, 53, 1);
    run_msg("clean",    exp_tag,                 0, 1'b0, 1'b1, 53, -1);
    run_msg("badtag",   exp_tag ^ 128'd1,        0, 1'b0, 1'b0, 53, -1);
    run_msg("stray",    exp_tag,                 0, 1'b1, 1'b1, 53, -1);
    run_msg("gap5",     exp_tag,                 5, 1'b0, 1'b1, 73, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
